// File: rtl/sr_bank_pkg.sv
// sr_bank_pkg: shared constants and helpers for the set/reset flag bank.
//   MODE_*   set&clr same-cycle policy codes
//   lock_w() lockout down-counter width for a given lockout length
package sr_bank_pkg;

   localparam int MODE_HOLD = 0;
   localparam int MODE_SET  = 1;
   localparam int MODE_CLR  = 2;
   localparam int MODE_TOG  = 3;

   // Enough bits to hold n; a zero-length lockout still gets one bit so the
   // counter vector is never zero-width.
   function automatic int lock_w(input int n);
      int w;
      w = $clog2(n + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/sr_flag_cell.sv
// sr_flag_cell: one synchronous SR flag channel with conflict policy and
// post-change lockout.
//   clk, reset     clock, synchronous active-high reset
//   en             request qualifier
//   set_req        set request (level)
//   clr_req        clear request (level)
//   q              registered flag state
//   rise, fall     one-cycle pulses in the first cycle q reads 1 / 0
//   busy           lockout active, requests are dropped
//   conflict_hit   set&clr&en this cycle (combinational, registered by the top)
module sr_flag_cell
   import sr_bank_pkg::*;
#(
   parameter int   CONFLICT_MODE = MODE_HOLD,
   parameter int   LOCK_CYCLES   = 0,
   parameter logic RESET_BIT     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic set_req,
   input  logic clr_req,
   output logic q,
   output logic rise,
   output logic fall,
   output logic busy,
   output logic conflict_hit
);

   localparam int          CW       = lock_w(LOCK_CYCLES);
   localparam logic [CW-1:0] LOCK_VAL = CW'(LOCK_CYCLES);

   logic [CW-1:0] cnt;
   logic          q_nxt;
   logic          changed;

   assign busy         = (cnt != '0);
   assign conflict_hit = en & set_req & clr_req;

   always_comb begin
      q_nxt = q;
      // Requests arriving while locked are dropped outright, not queued.
      if (en && !busy) begin
         if (set_req && !clr_req) begin
            q_nxt = 1'b1;
         end else if (clr_req && !set_req) begin
            q_nxt = 1'b0;
         end else if (set_req && clr_req) begin
            if (CONFLICT_MODE == MODE_SET) begin
               q_nxt = 1'b1;
            end else if (CONFLICT_MODE == MODE_CLR) begin
               q_nxt = 1'b0;
            end else if (CONFLICT_MODE == MODE_TOG) begin
               q_nxt = ~q;
            end
         end
      end
   end

   // A request equal to the current state is not a change: no pulse, no lockout.
   assign changed = (q_nxt != q);

   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= RESET_BIT;
         rise <= 1'b0;
         fall <= 1'b0;
         cnt  <= '0;
      end else begin
         q    <= q_nxt;
         rise <= changed & q_nxt;
         fall <= changed & ~q_nxt;
         // Down-counter: reload on every change, otherwise count to zero and stop.
         if (changed) begin
            cnt <= LOCK_VAL;
         end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
         end
      end
   end

endmodule

// File: rtl/sr_flag_bank.sv
// sr_flag_bank: parametrised bank of N_CH set/reset flags guarding the
// magnetron enable path, with per-channel lockout and a sticky conflict flag.
//   clk, reset      clock, synchronous active-high reset
//   en              request qualifier for all channels
//   set_req/clr_req per-channel set / clear requests
//   conflict_clr    clears the sticky conflict flag
//   q               flag state
//   rise/fall       per-channel change pulses
//   busy            per-channel lockout indicator
//   conflict        sticky: some channel saw set&clr with en=1
module sr_flag_bank
   import sr_bank_pkg::*;
#(
   parameter int              N_CH          = 4,
   parameter int              CONFLICT_MODE = MODE_HOLD,
   parameter int              LOCK_CYCLES   = 0,
   parameter logic [N_CH-1:0] RESET_VAL     = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [N_CH-1:0] set_req,
   input  logic [N_CH-1:0] clr_req,
   input  logic            conflict_clr,
   output logic [N_CH-1:0] q,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall,
   output logic [N_CH-1:0] busy,
   output logic            conflict
);

   if (CONFLICT_MODE < MODE_HOLD || CONFLICT_MODE > MODE_TOG) begin : g_bad_mode
      $error("sr_flag_bank: CONFLICT_MODE must be 0..3");
   end
   if (N_CH < 1) begin : g_bad_nch
      $error("sr_flag_bank: N_CH must be at least 1");
   end
   if (LOCK_CYCLES < 0) begin : g_bad_lock
      $error("sr_flag_bank: LOCK_CYCLES must be non-negative");
   end

   logic [N_CH-1:0] conflict_hit;

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      sr_flag_cell #(
         .CONFLICT_MODE (CONFLICT_MODE),
         .LOCK_CYCLES   (LOCK_CYCLES),
         .RESET_BIT     (RESET_VAL[i])
      ) u_cell (
         .clk          (clk),
         .reset        (reset),
         .en           (en),
         .set_req      (set_req[i]),
         .clr_req      (clr_req[i]),
         .q            (q[i]),
         .rise         (rise[i]),
         .fall         (fall[i]),
         .busy         (busy[i]),
         .conflict_hit (conflict_hit[i])
      );
   end

   // A fresh conflict outranks a simultaneous clear so no event is lost.
   always_ff @(posedge clk) begin
      if (reset) begin
         conflict <= 1'b0;
      end else if (|conflict_hit) begin
         conflict <= 1'b1;
      end else if (conflict_clr) begin
         conflict <= 1'b0;
      end
   end

endmodule
